// File: rtl/win_pkg.sv
// Shared constants for the 3x3 window streamer: default frame geometry, tap indices,
// FSM state encodings and the coordinate-width helper.
package win_pkg;

  localparam int WIN_BIT_LENGTH = 5;
  localparam int WIN_IMG_W      = 20;
  localparam int WIN_IMG_H      = 20;

  // Row-major tap indices within the packed 3x3 window
  localparam int TL  = 0;
  localparam int TC  = 1;
  localparam int TR  = 2;
  localparam int ML  = 3;
  localparam int CTR = 4;
  localparam int MR  = 5;
  localparam int BL  = 6;
  localparam int BC  = 7;
  localparam int BR  = 8;

  localparam logic [0:0] WAIT_PIX = 1'b0;
  localparam logic [0:0] PAD_STEP = 1'b1;

  function automatic int coord_width(input int w, input int h);
    return $clog2(((w > h) ? w : h) + 1);
  endfunction

endpackage

// File: rtl/win_line_buffer.sv
// DEPTH-stage shift delay line; dout is the sample shifted in DEPTH enabled shifts ago.
module win_line_buffer
  import win_pkg::*;
#(
  parameter int DEPTH      = WIN_IMG_W,
  parameter int BIT_LENGTH = WIN_BIT_LENGTH
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [BIT_LENGTH-1:0] din,
  output logic [BIT_LENGTH-1:0] dout
);

  logic [BIT_LENGTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/win3x3_stream.sv
// Streaming 3x3 neighbourhood generator with two line buffers and full backpressure.
// Define WIN_ZERO_PAD_EN to emit zero-padded windows for every pixel instead of interior ones only.
module win3x3_stream
  import win_pkg::*;
#(
  parameter int IMG_W      = WIN_IMG_W,
  parameter int IMG_H      = WIN_IMG_H,
  parameter int BIT_LENGTH = WIN_BIT_LENGTH,
  parameter int CW         = coord_width(IMG_W, IMG_H)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIT_LENGTH-1:0]   in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9*BIT_LENGTH-1:0] out_win,
  output logic [CW-1:0]           out_row,
  output logic [CW-1:0]           out_col,
  output logic                    out_last,
  output logic                    busy
);

`ifdef WIN_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int GW  = IMG_W + 1;
  localparam int GH  = IMG_H + 1;
`else
  localparam bit PAD = 1'b0;
  localparam int GW  = IMG_W;
  localparam int GH  = IMG_H;
`endif

  logic [CW-1:0] r, c, next_r, next_c, ctr_r, ctr_c;
  logic [0:0]    state, next_state;
  logic          real_pos, stall, step, complete, is_last;
  logic          valid_q, last_q;
  logic [9*BIT_LENGTH-1:0] win_q, win_next;
  logic [CW-1:0] row_q, col_q;
  logic [BIT_LENGTH-1:0] shift_pix, lb1_out, lb2_out;
  logic [BIT_LENGTH-1:0] col0 [3];
  logic [BIT_LENGTH-1:0] col1 [3];
  logic [BIT_LENGTH-1:0] col_new [3];

  assign real_pos  = (state == WAIT_PIX);
  assign stall     = valid_q && !out_ready;
  assign step      = !reset && !stall && (real_pos ? in_valid : 1'b1);
  assign shift_pix = real_pos ? in_pixel : '0;
  assign ctr_r     = r - CW'(1);
  assign ctr_c     = c - CW'(1);

  always_comb begin
    next_r = r;
    next_c = c + CW'(1);
    if (c == CW'(GW - 1)) begin
      next_c = '0;
      next_r = (r == CW'(GH - 1)) ? '0 : r + CW'(1);
    end
    next_state = (next_r < CW'(IMG_H) && next_c < CW'(IMG_W)) ? WAIT_PIX : PAD_STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r     <= '0;
      c     <= '0;
      state <= WAIT_PIX;
    end else if (step) begin
      r     <= next_r;
      c     <= next_c;
      state <= next_state;
    end
  end

  win_line_buffer #(.DEPTH(GW), .BIT_LENGTH(BIT_LENGTH)) u_lb1 (
    .clk(clk), .shift_en(step), .din(shift_pix), .dout(lb1_out)
  );

  win_line_buffer #(.DEPTH(GW), .BIT_LENGTH(BIT_LENGTH)) u_lb2 (
    .clk(clk), .shift_en(step), .din(lb1_out), .dout(lb2_out)
  );

  assign col_new[0] = lb2_out;
  assign col_new[1] = lb1_out;
  assign col_new[2] = shift_pix;

  // col1 holds column c-1 and col0 column c-2 of rows r-2..r
  always_ff @(posedge clk) begin
    if (step) begin
      for (int i = 0; i < 3; i++) begin
        col0[i] <= col1[i];
        col1[i] <= col_new[i];
      end
    end
  end

  // Taps outside the frame are forced to zero so stale buffer data never shows
  always_comb begin
    logic [BIT_LENGTH-1:0] tap;
    logic top_out, bot_out, left_out, right_out;
    tap       = '0;
    win_next  = '0;
    top_out   = (ctr_r == '0);
    bot_out   = (ctr_r == CW'(IMG_H - 1));
    left_out  = (ctr_c == '0);
    right_out = (ctr_c == CW'(IMG_W - 1));
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j == 0)      tap = col0[i];
        else if (j == 1) tap = col1[i];
        else             tap = col_new[i];
        if ((i == 0 && top_out) || (i == 2 && bot_out) ||
            (j == 0 && left_out) || (j == 2 && right_out)) begin
          tap = '0;
        end
        win_next[(TL + i*3 + j)*BIT_LENGTH +: BIT_LENGTH] = tap;
      end
    end
  end

  always_comb begin
    if (PAD) begin
      complete = step && (r >= CW'(1)) && (c >= CW'(1));
      is_last  = (ctr_r == CW'(IMG_H - 1)) && (ctr_c == CW'(IMG_W - 1));
    end else begin
      complete = step && (r >= CW'(2)) && (c >= CW'(2));
      is_last  = (ctr_r == CW'(IMG_H - 2)) && (ctr_c == CW'(IMG_W - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      win_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else if (complete) begin
      valid_q <= 1'b1;
      win_q   <= win_next;
      row_q   <= ctr_r;
      col_q   <= ctr_c;
      last_q  <= is_last;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign in_ready  = !reset && !stall && real_pos;
  assign out_valid = !reset && valid_q;
  assign out_win   = reset ? '0 : win_q;
  assign out_row   = reset ? '0 : row_q;
  assign out_col   = reset ? '0 : col_q;
  assign out_last  = !reset && last_q;
  assign busy      = !reset && ((r != '0) || (c != '0) || valid_q);

endmodule

// File: tb/tb_win3x3_stream.sv
// Self-checking bench for win3x3_stream on a 4x4 frame with ramp pixels 4r+c.
// Pad scenario runs when WIN_ZERO_PAD_EN is defined, the interior scenarios otherwise.
module tb_win3x3_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [BW-1:0]   in_pixel;
  logic [9*BW-1:0] out_win;
  logic [CW-1:0]   out_row, out_col;

  typedef struct {
    int          row;
    int          col;
    logic [44:0] win;
    bit          last;
  } win_rec_t;

  win_rec_t exp_tab [4];
  win_rec_t got_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_last   = 0;

  always #5 clk = ~clk;

  win3x3_stream #(.IMG_W(W), .IMG_H(H), .BIT_LENGTH(BW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_win(out_win), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy)
  );

  // Record every accepted window
  always @(negedge clk) begin
    win_rec_t rec;
    if (!reset && out_valid && out_ready) begin
      rec.row  = int'(out_row);
      rec.col  = int'(out_col);
      rec.win  = out_win;
      rec.last = out_last;
      got_q.push_back(rec);
      if (out_last) n_last++;
    end
  end

  function automatic logic [44:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {5'(a8), 5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic failTimeout(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Sends npix ramp pixels (value p mod 16), optionally with random idle cycles
  task automatic applyStimulus(input int npix, input bit bubbles);
    for (int p = 0; p < npix; p++) begin
      int g;
      bit acc;
      g = 0;
      if (bubbles) begin
        while ($urandom_range(1, 0) == 1 && g < 4) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          g++;
        end
      end
      in_valid = 1'b1;
      in_pixel = BW'(p % 16);
      g = 0;
      acc = 1'b0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 200);
      if (!acc) begin
        failTimeout("pixel accept");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic checkWindows(input string tag, input int nexp);
    checkOutput({tag, " count"}, got_q.size(), nexp);
    for (int i = 0; i < nexp && i < got_q.size(); i++) begin
      checkOutput($sformatf("%s w%0d row", tag, i), got_q[i].row, exp_tab[i % 4].row);
      checkOutput($sformatf("%s w%0d col", tag, i), got_q[i].col, exp_tab[i % 4].col);
      checkOutput($sformatf("%s w%0d win", tag, i), got_q[i].win, exp_tab[i % 4].win);
      checkOutput($sformatf("%s w%0d last", tag, i), got_q[i].last, exp_tab[i % 4].last);
    end
    got_q.delete();
  endtask

  task automatic stallFive();
    int g;
    logic [44:0] w;
    logic [2*CW-1:0] rc;
    g = 0;
    while (!out_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!out_valid) begin
      failTimeout("stall wait");
      return;
    end
    out_ready = 1'b0;
    w  = out_win;
    rc = {out_row, out_col};
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall win stable", out_win, w);
      checkOutput("stall coord stable", {out_row, out_col}, rc);
      checkOutput("stall in_ready", in_ready, 1'b0);
      checkOutput("stall out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;

    exp_tab[0] = '{1, 1, pk(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
    exp_tab[1] = '{1, 2, pk(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
    exp_tab[2] = '{2, 1, pk(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
    exp_tab[3] = '{2, 2, pk(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset outputs", {in_ready, out_valid, busy, out_last, out_row, out_col, out_win}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", in_ready, 1'b1);
    checkOutput("post-reset busy", busy, 1'b0);
    @(posedge clk); #1;

`ifdef WIN_ZERO_PAD_EN
    begin
      int low;
      low = 0;
      n_last = 0;
      fork
        applyStimulus(16, 1'b0);
        repeat (40) begin
          @(negedge clk);
          if (busy && !in_ready) low++;
        end
      join
      #1;
      checkOutput("pad virtual steps", low, 9);
      checkOutput("pad count", got_q.size(), 16);
      checkOutput("pad last count", n_last, 1);
      if (got_q.size() == 16) begin
        checkOutput("pad first coord", {got_q[0].row, got_q[0].col}, {32'd0, 32'd0});
        checkOutput("pad first win", got_q[0].win, pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
        checkOutput("pad final coord", {got_q[15].row, got_q[15].col}, {32'd3, 32'd3});
        checkOutput("pad final win", got_q[15].win, pk(10, 11, 0, 14, 15, 0, 0, 0, 0));
        checkOutput("pad final last", got_q[15].last, 1'b1);
      end
      got_q.delete();
    end
`else
    $display("[TB] ramp frame");
    applyStimulus(16, 1'b0);
    drain();
    checkWindows("ramp", 4);
    checkOutput("ramp idle busy", busy, 1'b0);

    $display("[TB] backpressure");
    fork
      applyStimulus(16, 1'b0);
      stallFive();
    join
    drain();
    checkWindows("stall", 4);

    $display("[TB] input bubbles");
    applyStimulus(16, 1'b1);
    drain();
    checkWindows("bubble", 4);

    $display("[TB] reset mid-frame");
    applyStimulus(7, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset out_valid", out_valid, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    got_q.delete();
    applyStimulus(16, 1'b0);
    drain();
    checkWindows("fresh", 4);

    $display("[TB] back-to-back frames");
    n_last = 0;
    applyStimulus(32, 1'b0);
    drain();
    checkOutput("b2b last count", n_last, 2);
    checkWindows("b2b", 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
